hopfield_engine: RTL and testbench

- Time-multiplexed, parametrised Hopfield associative-memory engine; successor to the fixed 25-neuron fully parallel network.
- A single signed MAC evaluates N neurons sequentially against a writable N×N weight register file.
- Runs synchronous or asynchronous update mode until the state is stable or MAX_ITER is reached.
- Sits between the pattern source (host/testbench) and the recall consumer, with start/done handshake.

---
 rtl/hopfield_pkg.sv | 20 ++
 rtl/hopfield_weight_rf.sv | 27 ++
 rtl/hopfield_engine.sv | 179 +++++++++++++++++
 tb/tb_hopfield_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hopfield_pkg.sv
// Shared types and constants for the time-multiplexed Hopfield engine.
package hopfield_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MAC    = 3'd1,
    ST_UPDATE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic MODE_SYNC  = 1'b0;
  localparam logic MODE_ASYNC = 1'b1;

  // Worst-case |sum| is N * 2^(WW-1), so one guard bit on top of WW+clog2(N).
  function automatic int acc_width(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/hopfield_weight_rf.sv
// N x N signed weight register file: one synchronous write port, one combinational read port.
module hopfield_weight_rf #(
  parameter int N  = 25,
  parameter int WW = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic        [$clog2(N)-1:0]  wr_row,
  input  logic        [$clog2(N)-1:0]  wr_col,
  input  logic signed [WW-1:0]         wr_data,
  input  logic        [$clog2(N)-1:0]  rd_row,
  input  logic        [$clog2(N)-1:0]  rd_col,
  output logic signed [WW-1:0]         rd_data
);

  // Weights deliberately survive reset so a recall can be re-run after an abort.
  logic signed [WW-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/hopfield_engine.sv
// Hopfield recall engine: one signed MAC walks all neurons, iterating until stable or MAX_ITER.
module hopfield_engine
  import hopfield_pkg::*;
#(
  parameter int N        = 25,
  parameter int WW       = 8,
  parameter int MAX_ITER = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               w_we,
  input  logic        [$clog2(N)-1:0]        w_row,
  input  logic        [$clog2(N)-1:0]        w_col,
  input  logic signed [WW-1:0]               w_data,
  input  logic                               start,
  input  logic                               mode,
  input  logic        [N-1:0]                pattern_in,
  output logic                               busy,
  output logic                               done,
  output logic                               converged,
  output logic        [N-1:0]                state_out,
  output logic        [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int AW = acc_width(N, WW);

  state_t                state_r, state_nxt;
  logic                  mode_r;
  logic [IW-1:0]         i_r, j_r;
  logic signed [AW-1:0]  acc_r, acc_nxt, w_ext;
  logic signed [WW-1:0]  w_rd;
  logic                  changed_r;
  logic [N-1:0]          next_r, state_out_r;
  logic [CW-1:0]         iter_r;
  logic                  busy_r, done_r, conv_r;
  logic                  src_bit, cur_bit, new_bit;
  logic                  last_j, last_i, last_iter, accept, w_en;

  // busy lingers one cycle past DONE, so IDLE alone does not mean the engine is free.
  assign accept    = (state_r == ST_IDLE) && start && !busy_r;
  assign w_en      = w_we && (state_r == ST_IDLE) && !busy_r;
  assign last_j    = (j_r == IW'(N - 1));
  assign last_i    = (i_r == IW'(N - 1));
  assign last_iter = (iter_r == CW'(MAX_ITER - 1));

  hopfield_weight_rf #(.N(N), .WW(WW)) u_rf (
    .clk     (clk),
    .we      (w_en),
    .wr_row  (w_row),
    .wr_col  (w_col),
    .wr_data (w_data),
    .rd_row  (i_r),
    .rd_col  (j_r),
    .rd_data (w_rd)
  );

  // MAC step and threshold; a zero sum keeps the current bit.
  always_comb begin
    w_ext   = AW'(w_rd);
    src_bit = state_out_r[j_r];
    cur_bit = state_out_r[i_r];
    acc_nxt = src_bit ? (acc_r + w_ext) : (acc_r - w_ext);
    if (acc_r == '0) begin
      new_bit = cur_bit;
    end else if (acc_r[AW-1]) begin
      new_bit = 1'b0;
    end else begin
      new_bit = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:   state_nxt = accept ? ST_MAC : ST_IDLE;
      ST_MAC:    state_nxt = last_j ? ST_UPDATE : ST_MAC;
      ST_UPDATE: state_nxt = last_i ? ST_CHECK : ST_MAC;
      ST_CHECK:  state_nxt = (!changed_r || last_iter) ? ST_DONE : ST_MAC;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= MODE_SYNC;
      i_r         <= '0;
      j_r         <= '0;
      acc_r       <= '0;
      changed_r   <= 1'b0;
      next_r      <= '0;
      state_out_r <= '0;
      iter_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      conv_r      <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (done_r) begin
            busy_r <= 1'b0;
          end
          if (accept) begin
            state_out_r <= pattern_in;
            next_r      <= pattern_in;
            mode_r      <= mode;
            i_r         <= '0;
            j_r         <= '0;
            acc_r       <= '0;
            changed_r   <= 1'b0;
            iter_r      <= '0;
            conv_r      <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_MAC: begin
          acc_r <= acc_nxt;
          j_r   <= j_r + IW'(1);
        end
        ST_UPDATE: begin
          if (new_bit != cur_bit) begin
            changed_r <= 1'b1;
          end
          if (mode_r == MODE_ASYNC) begin
            state_out_r[i_r] <= new_bit;
          end else begin
            next_r[i_r] <= new_bit;
          end
          acc_r <= '0;
          j_r   <= '0;
          if (!last_i) begin
            i_r <= i_r + IW'(1);
          end
        end
        ST_CHECK: begin
          iter_r <= iter_r + CW'(1);
          if (mode_r == MODE_SYNC) begin
            state_out_r <= next_r;
          end
          if (!changed_r) begin
            conv_r <= 1'b1;
          end else if (last_iter) begin
            conv_r <= 1'b0;
          end else begin
            changed_r <= 1'b0;
            i_r       <= '0;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign converged  = conv_r;
  assign state_out  = state_out_r;
  assign iter_count = iter_r;

endmodule

// File: tb/tb_hopfield_engine.sv
// Bench for hopfield_engine: three instances (N=4/MAX_ITER=16, N=4/MAX_ITER=1, N=2/MAX_ITER=16) vs. a recall model.
module tb_hopfield_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  int         sel;
  logic       g_we, g_start, g_mode;
  logic [1:0] g_row, g_col;
  logic [7:0] g_data;
  logic [3:0] g_pat;

  logic a_busy, a_done, a_conv; logic [3:0] a_state; logic [4:0] a_iter;
  logic b_busy, b_done, b_conv; logic [3:0] b_state; logic [0:0] b_iter;
  logic c_busy, c_done, c_conv; logic [1:0] c_state; logic [4:0] c_iter;

  logic cur_busy, cur_done, cur_conv; logic [3:0] cur_state; logic [4:0] cur_iter;

  int n_checks = 0;
  int n_errors = 0;
  int wm [3][4][4];

  hopfield_engine #(.N(4), .WW(8), .MAX_ITER(16)) u_a (
    .clk(clk), .rst(rst), .w_we(g_we && sel == 0), .w_row(g_row), .w_col(g_col), .w_data(g_data),
    .start(g_start && sel == 0), .mode(g_mode), .pattern_in(g_pat),
    .busy(a_busy), .done(a_done), .converged(a_conv), .state_out(a_state), .iter_count(a_iter));

  hopfield_engine #(.N(4), .WW(8), .MAX_ITER(1)) u_b (
    .clk(clk), .rst(rst), .w_we(g_we && sel == 1), .w_row(g_row), .w_col(g_col), .w_data(g_data),
    .start(g_start && sel == 1), .mode(g_mode), .pattern_in(g_pat),
    .busy(b_busy), .done(b_done), .converged(b_conv), .state_out(b_state), .iter_count(b_iter));

  hopfield_engine #(.N(2), .WW(8), .MAX_ITER(16)) u_c (
    .clk(clk), .rst(rst), .w_we(g_we && sel == 2), .w_row(g_row[0]), .w_col(g_col[0]), .w_data(g_data),
    .start(g_start && sel == 2), .mode(g_mode), .pattern_in(g_pat[1:0]),
    .busy(c_busy), .done(c_done), .converged(c_conv), .state_out(c_state), .iter_count(c_iter));

  always_comb begin
    case (sel)
      1: begin
        cur_busy = b_busy; cur_done = b_done; cur_conv = b_conv;
        cur_state = b_state; cur_iter = {4'b0000, b_iter};
      end
      2: begin
        cur_busy = c_busy; cur_done = c_done; cur_conv = c_conv;
        cur_state = {2'b00, c_state}; cur_iter = c_iter;
      end
      default: begin
        cur_busy = a_busy; cur_done = a_done; cur_conv = a_conv;
        cur_state = a_state; cur_iter = a_iter;
      end
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Straight evaluation of the Hopfield rules on +1/-1 neuron values.
  function automatic void ref_recall(input int inst, input int n, input int maxit, input int md,
                                     input int pat, output int st, output int conv, output int it);
    int s [4];
    int nx [4];
    int sum, nb;
    bit chg;
    for (int k = 0; k < n; k++) s[k] = ((pat >> k) & 1) != 0 ? 1 : -1;
    it = 0;
    conv = 0;
    while (1) begin
      it++;
      chg = 0;
      for (int i = 0; i < n; i++) begin
        sum = 0;
        for (int j = 0; j < n; j++) sum += wm[inst][i][j] * s[j];
        nb = (sum > 0) ? 1 : (sum < 0) ? -1 : s[i];
        if (nb != s[i]) chg = 1;
        if (md != 0) s[i] = nb;
        else nx[i] = nb;
      end
      if (md == 0) for (int k = 0; k < n; k++) s[k] = nx[k];
      if (!chg) begin
        conv = 1;
        break;
      end
      if (it == maxit) break;
    end
    st = 0;
    for (int k = 0; k < n; k++) if (s[k] > 0) st |= (1 << k);
  endfunction

  task automatic wr(input int inst, input int i, input int j, input int v);
    sel = inst;
    g_row = 2'(i);
    g_col = 2'(j);
    g_data = 8'(v);
    g_we = 1'b1;
    @(posedge clk);
    #1 g_we = 1'b0;
    wm[inst][i][j] = v;
  endtask

  // Runs one recall; optionally injects start+write while busy, or aborts with reset.
  task automatic recall(input int inst, input int md, input int pat, input int inject_at,
                        input int abort_at, input string tag,
                        output int o_st, output int o_conv, output int o_it, output int o_cyc);
    int n, maxit, e_st, e_conv, e_it, e_cyc, cnt, late_done;
    bit seen;
    n = (inst == 2) ? 2 : 4;
    maxit = (inst == 1) ? 1 : 16;
    ref_recall(inst, n, maxit, md, pat, e_st, e_conv, e_it);
    e_cyc = e_it * (n * (n + 1) + 1) + 1;
    sel = inst;
    g_mode = md[0];
    g_pat = 4'(pat);
    g_start = 1'b1;
    @(posedge clk);
    #1 g_start = 1'b0;
    chk({tag, "_busy_after_start"}, cur_busy, 1);
    cnt = 0;
    seen = 0;
    o_st = 0; o_conv = 0; o_it = 0; o_cyc = 0;
    while (cnt < 2000 && !seen) begin
      if (cnt == inject_at) begin
        g_start = 1'b1;
        g_pat = ~g_pat;
        g_we = 1'b1;
        g_row = 2'($urandom_range(0, 3));
        g_col = 2'($urandom_range(0, 3));
        g_data = 8'($urandom_range(0, 255));
      end
      if (cnt == abort_at) begin
        #3 rst = 1'b1;
        #1 chk({tag, "_outputs_in_reset"}, {cur_busy, cur_done, cur_conv, cur_state, cur_iter}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        late_done = 0;
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1 if (cur_done || cur_busy) late_done++;
        end
        chk({tag, "_no_done_after_abort"}, late_done, 0);
        return;
      end
      @(posedge clk);
      #1 g_start = 1'b0;
      g_we = 1'b0;
      cnt++;
      if (cur_done) seen = 1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    o_st = cur_state; o_conv = cur_conv; o_it = cur_iter; o_cyc = cnt;
    chk({tag, "_cycles"}, cnt, e_cyc);
    chk({tag, "_state"}, cur_state, e_st);
    chk({tag, "_converged"}, cur_conv, e_conv);
    chk({tag, "_iter"}, cur_iter, e_it);
    @(posedge clk);
    #1 chk({tag, "_done_one_cycle"}, cur_done, 0);
    chk({tag, "_busy_cleared"}, cur_busy, 0);
  endtask

  task automatic load_hebb(input int inst);
    int xi, xj;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        xi = ((5 >> i) & 1) != 0 ? 1 : -1;
        xj = ((5 >> j) & 1) != 0 ? 1 : -1;
        wr(inst, i, j, (i == j) ? 0 : xi * xj);
      end
  endtask

  initial begin
    int st, cv, it, cyc, st2, cv2, it2, inst, n;
    rst = 1'b1;
    sel = 0;
    g_we = 1'b0; g_start = 1'b0; g_mode = 1'b0;
    g_row = 2'd0; g_col = 2'd0; g_data = 8'd0; g_pat = 4'd0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1 chk("reset_outputs", {cur_busy, cur_done, cur_conv, cur_state, cur_iter}, 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    load_hebb(0);
    load_hebb(1);
    recall(0, 0, 4'b0100, -1, -1, "hebb_sync", st, cv, it, cyc);
    chk("hebb_sync_spec_cyc", cyc, 43);
    chk("hebb_sync_spec_state", st, 5);
    chk("hebb_sync_spec_conv", cv, 1);
    chk("hebb_sync_spec_iter", it, 2);

    recall(1, 0, 4'b0100, -1, -1, "iter_limit", st, cv, it, cyc);
    chk("iter_limit_spec_cyc", cyc, 22);
    chk("iter_limit_spec_state", st, 5);
    chk("iter_limit_spec_conv", cv, 0);
    chk("iter_limit_spec_iter", it, 1);

    recall(0, 0, 4'b0100, 5, -1, "guard", st, cv, it, cyc);
    recall(0, 0, 4'b0100, -1, -1, "guard_rerun", st2, cv2, it2, cyc);
    chk("guard_rerun_same_state", st2, st);
    chk("guard_rerun_same_iter", it2, it);

    recall(0, 0, 4'b0100, -1, 10, "abort", st, cv, it, cyc);
    recall(0, 0, 4'b0100, -1, -1, "after_abort", st, cv, it, cyc);
    chk("after_abort_spec_state", st, 5);
    chk("after_abort_spec_iter", it, 2);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wr(0, i, j, 0);
    recall(0, 0, 4'b0110, -1, -1, "zero_tie", st, cv, it, cyc);
    chk("zero_tie_spec_state", st, 6);
    chk("zero_tie_spec_conv", cv, 1);
    chk("zero_tie_spec_iter", it, 1);

    wr(2, 0, 0, 0); wr(2, 0, 1, -1); wr(2, 1, 0, -1); wr(2, 1, 1, 0);
    recall(2, 0, 2'b11, -1, -1, "osc_sync", st, cv, it, cyc);
    chk("osc_sync_spec_conv", cv, 0);
    chk("osc_sync_spec_iter", it, 16);
    recall(2, 1, 2'b11, -1, -1, "osc_async", st, cv, it, cyc);
    chk("osc_async_spec_state", st, 2);
    chk("osc_async_spec_conv", cv, 1);
    chk("osc_async_spec_iter", it, 2);

    for (int t = 0; t < 12; t++) begin
      inst = $urandom_range(0, 2);
      n = (inst == 2) ? 2 : 4;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          wr(inst, i, j, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)) - 128);
      recall(inst, $urandom_range(0, 1), $urandom_range(0, (1 << n) - 1), -1, -1, "random",
             st, cv, it, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
